// File: rtl/bsg_hb_tag_pkg.sv
// Shared definitions for the tag transmitter and the client-side decoder.
//   tag_state_e     : transmitter FSM states
//   *_pos_f         : bit position of each frame field, counted from the first bit sent
//   hdr_bits_f      : header length (start + data_not_reset + node_id + len)
//   cnt_width_f     : bit-counter width able to hold any field/sequence length
package bsg_hb_tag_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    HDR     = 3'd2,
    PAYLOAD = 3'd3,
    GAP     = 3'd4
  } tag_state_e;

  // Frame order, LSB-first within each field:
  //   start(1) | data_not_reset(1) | node_id | len | payload(len bits)
  function automatic int start_pos_f();
    return 0;
  endfunction

  function automatic int dnr_pos_f();
    return 1;
  endfunction

  function automatic int node_pos_f();
    return 2;
  endfunction

  function automatic int len_pos_f(input int node_id_width);
    return 2 + node_id_width;
  endfunction

  function automatic int hdr_bits_f(input int node_id_width, input int len_width);
    return 2 + node_id_width + len_width;
  endfunction

  function automatic int payload_pos_f(input int node_id_width, input int len_width);
    return hdr_bits_f(node_id_width, len_width);
  endfunction

  function automatic int max2_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width_f(input int hdr_bits, input int max_payload,
                                     input int init_ones, input int idle_cycles);
    int m;
    m = max2_f(max2_f(hdr_bits, max_payload), max2_f(init_ones, idle_cycles));
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bsg_hb_tag_tx_if.sv
// Packet/init request bundle between a producer and bsg_hb_tag_tx.
//   init           : pulse requesting a tag-network init sequence
//   v              : packet valid
//   ready          : transmitter accepts a packet or init request this cycle
//   node_id        : destination client
//   data_not_reset : 1 = data packet, 0 = client-reset packet
//   len            : number of payload bits
//   payload        : payload, bit 0 sent first
interface bsg_hb_tag_tx_if
  import bsg_hb_tag_pkg::*;
#(
  parameter int node_id_width_p     = 5,
  parameter int max_payload_width_p = 16,
  parameter int len_width_p         = $clog2(max_payload_width_p + 1)
);

  logic                           init;
  logic                           v;
  logic                           ready;
  logic [node_id_width_p-1:0]     node_id;
  logic                           data_not_reset;
  logic [len_width_p-1:0]         len;
  logic [max_payload_width_p-1:0] payload;

  modport master (
    output init, v, node_id, data_not_reset, len, payload,
    input  ready
  );

  modport slave (
    input  init, v, node_id, data_not_reset, len, payload,
    output ready
  );

endinterface

// File: rtl/bsg_hb_tag_shifter.sv
// Loadable LSB-first shift register with a down-counter.
//   load_i / load_data_i      : parallel load (wins over shift)
//   shift_i / fill_i          : shift right by one, fill_i enters at the MSB
//   cnt_load_i / cnt_val_i    : counter load (wins over decrement)
//   bit_o                     : current serial bit (register LSB)
//   last_o                    : counter is on the final cycle of its field
module bsg_hb_tag_shifter #(
  parameter int width_p     = 28,
  parameter int cnt_width_p = 6
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [width_p-1:0]     load_data_i,
  input  logic                   shift_i,
  input  logic                   fill_i,
  input  logic                   cnt_load_i,
  input  logic [cnt_width_p-1:0] cnt_val_i,
  output logic                   bit_o,
  output logic                   last_o
);

  logic [width_p-1:0]     data_r;
  logic [cnt_width_p-1:0] cnt_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_r <= '0;
    end else if (load_i) begin
      data_r <= load_data_i;
    end else if (shift_i) begin
      data_r <= {fill_i, data_r[width_p-1:1]};
    end
  end

  // Decrement is blocked at zero so an idle counter can never wrap.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (cnt_load_i) begin
      cnt_r <= cnt_val_i;
    end else if (shift_i && (cnt_r != '0)) begin
      cnt_r <= cnt_r - 1'b1;
    end
  end

  assign bit_o  = data_r[0];
  assign last_o = (cnt_r == cnt_width_p'(1));

endmodule

// File: rtl/bsg_hb_tag_tx.sv
// Tag-network serial transmitter. Accepts packets or init requests on the
// pkt bundle and serialises them onto tag_data_o, one bit per cycle.
//   clk_i      : the single clock, forwarded on tag_clk_o
//   reset_i    : asynchronous active-high reset; aborts any frame in flight
//   pkt        : slave side of the request bundle (init, v, ready, fields)
//   tag_clk_o  : forwarded clock
//   tag_en_o   : tag enable, high whenever out of reset
//   tag_data_o : serial bit, registered
module bsg_hb_tag_tx
  import bsg_hb_tag_pkg::*;
#(
  parameter int node_id_width_p     = 5,
  parameter int max_payload_width_p = 16,
  parameter int len_width_p         = $clog2(max_payload_width_p + 1),
  parameter int idle_cycles_p       = 4,
  parameter int init_ones_p         = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  bsg_hb_tag_tx_if.slave      pkt,
  output logic                tag_clk_o,
  output logic                tag_en_o,
  output logic                tag_data_o
);

  localparam int hdr_bits_lp    = hdr_bits_f(node_id_width_p, len_width_p);
  localparam int frame_width_lp = hdr_bits_lp + max_payload_width_p;
  localparam int cnt_width_lp   = cnt_width_f(hdr_bits_lp, max_payload_width_p,
                                              init_ones_p, idle_cycles_p);

  tag_state_e state_r, state_n;

  logic                      ready_r;
  logic                      en_r;
  logic [len_width_p-1:0]    len_r;
  logic [len_width_p-1:0]    len_clamped;
  logic [frame_width_lp-1:0] frame_word;

  logic                      accept_init;
  logic                      accept_pkt;

  logic                      sh_load;
  logic [frame_width_lp-1:0] sh_load_data;
  logic                      sh_shift;
  logic                      sh_fill;
  logic                      sh_cnt_load;
  logic [cnt_width_lp-1:0]   sh_cnt_val;
  logic                      sh_bit;
  logic                      sh_last;

  always_comb begin
    len_clamped = pkt.len;
    if (int'(pkt.len) > max_payload_width_p) begin
      len_clamped = len_width_p'(max_payload_width_p);
    end
  end

  // Whole frame is loaded at acceptance; HDR and PAYLOAD just keep shifting.
  assign frame_word = {pkt.payload, len_clamped, pkt.node_id, pkt.data_not_reset, 1'b1};

  // init wins over a simultaneous v; that packet stays pending.
  assign accept_init = ready_r & pkt.init;
  assign accept_pkt  = ready_r & pkt.v & ~pkt.init;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      en_r    <= 1'b0;
      len_r   <= '0;
    end else begin
      state_r <= state_n;
      ready_r <= (state_n == IDLE);
      en_r    <= 1'b1;
      if (accept_pkt) begin
        len_r <= len_clamped;
      end
    end
  end

  // The counter holds the cycles remaining in the current field, so sh_last
  // marks the final bit of the field and the next field is loaded on that edge.
  always_comb begin
    state_n      = state_r;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_shift     = 1'b0;
    sh_fill      = 1'b0;
    sh_cnt_load  = 1'b0;
    sh_cnt_val   = '0;
    unique case (state_r)
      IDLE: begin
        if (accept_init) begin
          state_n      = INIT;
          sh_load      = 1'b1;
          sh_load_data = '1;
          sh_cnt_load  = 1'b1;
          sh_cnt_val   = cnt_width_lp'(init_ones_p);
        end else if (accept_pkt) begin
          state_n      = HDR;
          sh_load      = 1'b1;
          sh_load_data = frame_word;
          sh_cnt_load  = 1'b1;
          sh_cnt_val   = cnt_width_lp'(hdr_bits_lp);
        end
      end
      INIT: begin
        sh_fill = 1'b1;
        if (sh_last) begin
          state_n     = GAP;
          sh_load     = 1'b1;
          sh_cnt_load = 1'b1;
          sh_cnt_val  = cnt_width_lp'(idle_cycles_p);
        end else begin
          sh_shift = 1'b1;
        end
      end
      HDR: begin
        if (sh_last) begin
          if (len_r == '0) begin
            state_n     = GAP;
            sh_load     = 1'b1;
            sh_cnt_load = 1'b1;
            sh_cnt_val  = cnt_width_lp'(idle_cycles_p);
          end else begin
            state_n     = PAYLOAD;
            sh_shift    = 1'b1;
            sh_cnt_load = 1'b1;
            sh_cnt_val  = cnt_width_lp'(len_r);
          end
        end else begin
          sh_shift = 1'b1;
        end
      end
      PAYLOAD: begin
        if (sh_last) begin
          state_n     = GAP;
          sh_load     = 1'b1;
          sh_cnt_load = 1'b1;
          sh_cnt_val  = cnt_width_lp'(idle_cycles_p);
        end else begin
          sh_shift = 1'b1;
        end
      end
      GAP: begin
        if (sh_last) begin
          state_n     = IDLE;
          sh_cnt_load = 1'b1;
        end else begin
          sh_shift = 1'b1;
        end
      end
      default: begin
        state_n     = IDLE;
        sh_load     = 1'b1;
        sh_cnt_load = 1'b1;
      end
    endcase
  end

  bsg_hb_tag_shifter #(
    .width_p     (frame_width_lp),
    .cnt_width_p (cnt_width_lp)
  ) shifter (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (sh_load),
    .load_data_i (sh_load_data),
    .shift_i     (sh_shift),
    .fill_i      (sh_fill),
    .cnt_load_i  (sh_cnt_load),
    .cnt_val_i   (sh_cnt_val),
    .bit_o       (sh_bit),
    .last_o      (sh_last)
  );

  assign pkt.ready  = ready_r;
  assign tag_clk_o  = clk_i;
  assign tag_en_o   = en_r;
  assign tag_data_o = sh_bit;

endmodule

// File: tb/tb_bsg_hb_tag_tx.sv
module tb_bsg_hb_tag_tx;
  import bsg_hb_tag_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic tag_clk, tag_en, tag_data;
  int   n_vec = 0;
  int   n_err = 0;

  bsg_hb_tag_tx_if #(
    .node_id_width_p(5), .max_payload_width_p(16), .len_width_p(5)
  ) pkt_if ();

  bsg_hb_tag_tx #(
    .node_id_width_p(5), .max_payload_width_p(16), .len_width_p(5),
    .idle_cycles_p(4), .init_ones_p(32)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .pkt        (pkt_if.slave),
    .tag_clk_o  (tag_clk),
    .tag_en_o   (tag_en),
    .tag_data_o (tag_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] node, input logic dnr,
                       input logic [4:0] len, input logic [15:0] pl);
    pkt_if.node_id        = node;
    pkt_if.data_not_reset = dnr;
    pkt_if.len            = len;
    pkt_if.payload        = pl;
  endtask

  function automatic int clamp_len(input logic [4:0] len);
    return (int'(len) > 16) ? 16 : int'(len);
  endfunction

  // Expected serial stream, bit i = i-th bit on the wire, gap zeros included.
  function automatic void model_frame(input logic [4:0] node, input logic dnr,
                                      input logic [4:0] len, input logic [15:0] pl,
                                      output logic [63:0] bits, output int n);
    int lc, p;
    logic [4:0] lf;
    lc   = clamp_len(len);
    lf   = 5'(lc);
    bits = '0;
    p    = 0;
    bits[p] = 1'b1; p = p + 1;
    bits[p] = dnr;  p = p + 1;
    for (int i = 0; i < 5; i++) begin bits[p] = node[i]; p = p + 1; end
    for (int i = 0; i < 5; i++) begin bits[p] = lf[i];   p = p + 1; end
    for (int i = 0; i < lc; i++) begin bits[p] = pl[i];  p = p + 1; end
    n = p + 4;
  endfunction

  // ASIC-side client: recover fields from a captured stream.
  function automatic void client_decode(input logic [63:0] b, output logic st,
                                        output logic dnr, output logic [4:0] node,
                                        output logic [4:0] len, output logic [15:0] pl,
                                        output logic [3:0] gap);
    int pp;
    st  = b[start_pos_f()];
    dnr = b[dnr_pos_f()];
    for (int i = 0; i < 5; i++) node[i] = b[node_pos_f() + i];
    for (int i = 0; i < 5; i++) len[i]  = b[len_pos_f(5) + i];
    pp = payload_pos_f(5, 5);
    pl = '0;
    for (int i = 0; i < 16; i++) if (i < int'(len)) pl[i] = b[pp + i];
    for (int i = 0; i < 4; i++) gap[i] = b[pp + int'(len) + i];
  endfunction

  task automatic capture(input int n, output logic [63:0] bits,
                         output int rdy_hi, output int en_lo);
    bits = '0; rdy_hi = 0; en_lo = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits[i] = tag_data;
      if (pkt_if.ready) rdy_hi++;
      if (!tag_en) en_lo++;
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!pkt_if.ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(pkt_if.ready), 64'd1);
  endtask

  task automatic send_and_check(input string tag, input logic [4:0] node, input logic dnr,
                                input logic [4:0] len, input logic [15:0] pl,
                                output logic [63:0] got);
    logic [63:0] exp;
    int n, rh, el;
    wait_ready({tag, "_rdy_in"});
    drive(node, dnr, len, pl);
    pkt_if.v = 1'b1;
    @(posedge clk);
    #1 pkt_if.v = 1'b0;
    model_frame(node, dnr, len, pl, exp, n);
    capture(n, got, rh, el);
    chk({tag, "_frame"}, got, exp);
    chk({tag, "_busy_ready"}, 64'(rh), 64'd0);
    chk({tag, "_en"}, 64'(el), 64'd0);
    @(negedge clk);
    chk({tag, "_ready_back"}, 64'(pkt_if.ready), 64'd1);
  endtask

  logic [63:0] got, exp;
  int          n, rh, el;
  logic        d_st, d_dnr;
  logic [4:0]  d_node, d_len;
  logic [15:0] d_pl, m;
  logic [3:0]  d_gap;
  logic [4:0]  r_node [6];
  logic        r_dnr  [6];
  logic [4:0]  r_len  [6];
  logic [15:0] r_pl   [6];

  initial begin
    reset = 1'b1;
    pkt_if.init = 1'b0;
    pkt_if.v    = 1'b0;
    drive(5'd0, 1'b0, 5'd0, 16'd0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_en", 64'(tag_en), 64'd0);
    chk("rst_data", 64'(tag_data), 64'd0);
    chk("rst_ready", 64'(pkt_if.ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_en", 64'(tag_en), 64'd1);
    chk("rel_ready", 64'(pkt_if.ready), 64'd1);
    chk("idle_data", 64'(tag_data), 64'd0);
    @(posedge clk); #1;
    chk("tag_clk", 64'(tag_clk), 64'd1);
    @(negedge clk);

    // node=3 dnr=1 len=4 payload=0xA, hand-computed stream
    drive(5'd3, 1'b1, 5'd4, 16'h000A);
    pkt_if.v = 1'b1;
    @(posedge clk);
    #1 pkt_if.v = 1'b0;
    capture(20, got, rh, el);
    chk("p1_frame", got, 64'h0A20F);
    chk("p1_busy_ready", 64'(rh), 64'd0);
    @(negedge clk);
    chk("p1_ready_c21", 64'(pkt_if.ready), 64'd1);

    // len=0, node=31, dnr=0: 12 header bits then gap
    drive(5'd31, 1'b0, 5'd0, 16'hFFFF);
    pkt_if.v = 1'b1;
    @(posedge clk);
    #1 pkt_if.v = 1'b0;
    capture(16, got, rh, el);
    chk("len0_frame", got, 64'h007D);
    chk("len0_busy_ready", 64'(rh), 64'd0);
    @(negedge clk);
    chk("len0_ready_c17", 64'(pkt_if.ready), 64'd1);

    // init with a simultaneous packet: init first, packet held until after
    drive(5'd7, 1'b1, 5'd3, 16'h0005);
    pkt_if.v    = 1'b1;
    pkt_if.init = 1'b1;
    @(posedge clk);
    #1 pkt_if.init = 1'b0;
    capture(36, got, rh, el);
    chk("init_seq", got, 64'h0_FFFF_FFFF);
    chk("init_busy_ready", 64'(rh), 64'd0);
    @(negedge clk);
    chk("init_ready_back", 64'(pkt_if.ready), 64'd1);
    chk("init_idle_data", 64'(tag_data), 64'd0);
    @(posedge clk);
    #1 pkt_if.v = 1'b0;
    model_frame(5'd7, 1'b1, 5'd3, 16'h0005, exp, n);
    capture(n, got, rh, el);
    chk("init_pkt_frame", got, exp);
    @(negedge clk);

    // clamp: len 20 is sent as 16 with 16 payload bits
    send_and_check("clamp", 5'd5, 1'b1, 5'd20, 16'hBEEF, got);
    client_decode(got, d_st, d_dnr, d_node, d_len, d_pl, d_gap);
    chk("clamp_len_field", 64'(d_len), 64'd16);
    chk("clamp_payload", 64'(d_pl), 64'hBEEF);

    // reset during payload
    drive(5'd2, 1'b1, 5'd16, 16'hFFFF);
    pkt_if.v = 1'b1;
    @(posedge clk);
    #1 pkt_if.v = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_payload_bit", 64'(tag_data), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_data", 64'(tag_data), 64'd0);
    chk("async_rst_en", 64'(tag_en), 64'd0);
    chk("async_rst_ready", 64'(pkt_if.ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rel2_en", 64'(tag_en), 64'd1);
    chk("rel2_ready", 64'(pkt_if.ready), 64'd1);
    chk("rel2_data", 64'(tag_data), 64'd0);
    send_and_check("post_rst", 5'd9, 1'b1, 5'd5, 16'h0015, got);

    // back-to-back random packets with v held high
    for (int k = 0; k < 6; k++) begin
      r_node[k] = 5'($urandom);
      r_dnr[k]  = 1'($urandom);
      r_len[k]  = 5'($urandom_range(0, 20));
      r_pl[k]   = 16'($urandom);
    end
    wait_ready("b2b_rdy_in");
    drive(r_node[0], r_dnr[0], r_len[0], r_pl[0]);
    pkt_if.v = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (k < 5) drive(r_node[k+1], r_dnr[k+1], r_len[k+1], r_pl[k+1]);
      else pkt_if.v = 1'b0;
      model_frame(r_node[k], r_dnr[k], r_len[k], r_pl[k], exp, n);
      capture(n, got, rh, el);
      chk($sformatf("b2b%0d_frame", k), got, exp);
      chk($sformatf("b2b%0d_busy_ready", k), 64'(rh), 64'd0);
      client_decode(got, d_st, d_dnr, d_node, d_len, d_pl, d_gap);
      m = (clamp_len(r_len[k]) >= 16) ? 16'hFFFF : 16'((32'd1 << clamp_len(r_len[k])) - 1);
      chk($sformatf("b2b%0d_start", k), 64'(d_st), 64'd1);
      chk($sformatf("b2b%0d_dnr", k), 64'(d_dnr), 64'(r_dnr[k]));
      chk($sformatf("b2b%0d_node", k), 64'(d_node), 64'(r_node[k]));
      chk($sformatf("b2b%0d_len", k), 64'(d_len), 64'(clamp_len(r_len[k])));
      chk($sformatf("b2b%0d_payload", k), 64'(d_pl), 64'(r_pl[k] & m));
      chk($sformatf("b2b%0d_gap", k), 64'(d_gap), 64'd0);
      @(negedge clk);
      chk($sformatf("b2b%0d_ready", k), 64'(pkt_if.ready), 64'd1);
      chk($sformatf("b2b%0d_idle_bit", k), 64'(tag_data), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
